// File: rtl/mac_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_accum                                                                |
// | 64-entry Q8.8 multiply-accumulate buffer with a ready/valid drain port.  |
// | Optional build macro: MAC_SAT_EN (saturating accumulate, else wrapping). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mac_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  comp_en_mem,
    input  logic [15:0] in_act_value_mem,
    input  logic [5:0]  out_act_addr_mem,
    input  logic [15:0] w_mem_q,
    input  logic [15:0] u_mem_q,
    input  logic [15:0] v_mem_q,
    input  logic        acc_clear,
    input  logic        drain_start,
    input  logic [5:0]  drain_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_addr,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] c_EN_IDLE = 2'd0;
    localparam logic [1:0] c_EN_W    = 2'd1;
    localparam logic [1:0] c_EN_U    = 2'd2;
    localparam logic [1:0] c_EN_V    = 2'd3;
    localparam int         c_DEPTH   = 64;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [15:0]  r_entry [c_DEPTH];
    logic         r_p_valid;
    logic [15:0]  r_p_prod;
    logic [5:0]   r_p_addr;
    logic [5:0]   r_ptr;
    logic [5:0]   r_drain_last;
    logic         r_err;

    logic         w_busy;
    logic         w_drain;
    logic         w_capture;
    logic         w_clear;
    logic         w_xfer;
    logic [15:0]  w_weight;
    logic [23:0]  w_act_ext;
    logic [23:0]  w_wt_ext;
    logic [23:0]  w_prod;
    logic [15:0]  w_cur;
    logic [15:0]  w_acc_sum;

    assign w_busy    = (r_state != S_ACC);
    assign w_drain   = (r_state == S_DRAIN);
    assign w_capture = (comp_en_mem != c_EN_IDLE) && !w_busy;
    assign w_clear   = acc_clear && !w_busy;
    assign w_xfer    = out_valid && out_ready;

    always_comb begin
        w_weight = 16'h0000;
        case (comp_en_mem)
            c_EN_W:  w_weight = w_mem_q;
            c_EN_U:  w_weight = u_mem_q;
            c_EN_V:  w_weight = v_mem_q;
            default: w_weight = 16'h0000;
        endcase
    end

    // Only product bits [23:8] are kept, so a 24-bit modular multiply suffices.
    assign w_act_ext = {{8{in_act_value_mem[15]}}, in_act_value_mem};
    assign w_wt_ext  = {{8{w_weight[15]}}, w_weight};
    assign w_prod    = w_act_ext * w_wt_ext;

    assign w_cur = r_entry[r_p_addr];

`ifdef MAC_SAT_EN
    logic [16:0] w_sum_ext;
    assign w_sum_ext = {w_cur[15], w_cur} + {r_p_prod[15], r_p_prod};
    always_comb begin
        w_acc_sum = w_sum_ext[15:0];
        if (w_sum_ext[16] != w_sum_ext[15]) begin
            w_acc_sum = w_sum_ext[16] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    assign w_acc_sum = w_cur + r_p_prod;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACC:   if (drain_start)          w_state_nxt = S_FLUSH;
            S_FLUSH: if (!r_p_valid)           w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_xfer && out_last)   w_state_nxt = S_ACC;
            default:                           w_state_nxt = S_ACC;
        endcase
    end

    // Outputs are forced to zero outside DRAIN, which also covers reset.
    assign out_valid = w_drain;
    assign out_addr  = w_drain ? r_ptr : 6'd0;
    assign out_data  = w_drain ? r_entry[r_ptr] : 16'h0000;
    assign out_last  = w_drain && (r_ptr == r_drain_last);
    assign busy      = w_busy;
    assign err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_ACC;
            r_p_valid    <= 1'b0;
            r_p_prod     <= 16'h0000;
            r_p_addr     <= 6'd0;
            r_ptr        <= 6'd0;
            r_drain_last <= 6'd0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_p_valid <= w_capture;
            if (w_capture) begin
                r_p_prod <= w_prod[23:8];
                r_p_addr <= out_act_addr_mem;
            end
            if ((r_state == S_ACC) && drain_start) begin
                r_ptr        <= 6'd0;
                r_drain_last <= drain_last;
            end else if (w_xfer) begin
                r_ptr <= r_ptr + 6'd1;
            end
            if (w_busy && (acc_clear || drain_start || (comp_en_mem != c_EN_IDLE))) begin
                r_err <= 1'b1;
            end
        end
    end

    // Clear takes priority over a concurrent stage-A write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_entry[i] <= 16'h0000;
            end
        end else if (w_clear) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_entry[i] <= 16'h0000;
            end
        end else if (r_p_valid) begin
            r_entry[r_p_addr] <= w_acc_sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mac_accum                                                             |
// | Scoreboard bench for mac_accum; honours MAC_SAT_EN like the design.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mac_accum;

    localparam logic [1:0] EN_IDLE = 2'd0;
    localparam logic [1:0] EN_W    = 2'd1;
    localparam logic [1:0] EN_U    = 2'd2;
    localparam logic [1:0] EN_V    = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  comp_en_mem;
    logic [15:0] in_act_value_mem;
    logic [5:0]  out_act_addr_mem;
    logic [15:0] w_mem_q, u_mem_q, v_mem_q;
    logic        acc_clear, drain_start, out_ready;
    logic [5:0]  drain_last;
    logic        out_valid, out_last, busy, err;
    logic [5:0]  out_addr;
    logic [15:0] out_data;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [64];
    logic [22:0] sb [$];   // {addr, data, last}

    mac_accum dut (
        .clk              (clk),
        .rst              (rst),
        .comp_en_mem      (comp_en_mem),
        .in_act_value_mem (in_act_value_mem),
        .out_act_addr_mem (out_act_addr_mem),
        .w_mem_q          (w_mem_q),
        .u_mem_q          (u_mem_q),
        .v_mem_q          (v_mem_q),
        .acc_clear        (acc_clear),
        .drain_start      (drain_start),
        .drain_last       (drain_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] prod_q88(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[23:8];
    endfunction

    function automatic logic [15:0] add_acc(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef MAC_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 64; i++) model[i] = 16'h0000;
    endtask

    task automatic idle();
        comp_en_mem = EN_IDLE;
        acc_clear   = 1'b0;
        drain_start = 1'b0;
        out_ready   = 1'b0;
    endtask

    // Drives one _mem cycle (caller advances the clock) and updates the model.
    task automatic mac_set(input logic [1:0] en, input logic [15:0] act,
                           input logic [5:0] addr, input logic [15:0] wt);
        comp_en_mem      = en;
        in_act_value_mem = act;
        out_act_addr_mem = addr;
        w_mem_q = $urandom();
        u_mem_q = $urandom();
        v_mem_q = $urandom();
        case (en)
            EN_W: w_mem_q = wt;
            EN_U: u_mem_q = wt;
            EN_V: v_mem_q = wt;
            default: ;
        endcase
        model[addr] = add_acc(model[addr], prod_q88(act, wt));
    endtask

    task automatic clear_all();
        idle();
        repeat (2) @(negedge clk);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        model_zero();
    endtask

    // Drains 0..last; rdy_pat bit k is out_ready for the k-th valid cycle.
    task automatic run_drain(input logic [5:0] last, input logic [7:0] rdy_pat,
                             input int pat_len, input int clr_at);
        int          cyc;
        int          k;
        logic        stalled;
        logic        rdy;
        logic [5:0]  s_addr;
        logic [15:0] s_data;
        logic [22:0] e;
        drain_start = 1'b1;
        drain_last  = last;
        for (int i = 0; i <= int'(last); i++)
            sb.push_back({6'(i), model[i], (i == int'(last))});
        @(negedge clk);
        drain_start = 1'b0;
        comp_en_mem = EN_IDLE;
        cyc = 0; k = 0; stalled = 1'b0; s_addr = '0; s_data = '0;
        while (sb.size() > 0 && cyc < 300) begin
            out_ready = 1'b0; acc_clear = 1'b0; comp_en_mem = EN_IDLE;
            if (out_valid) begin
                if (stalled) begin
                    total++;
                    if ({out_addr, out_data} !== {s_addr, s_data}) begin
                        bad++;
                        $display("FAIL stall_hold: got addr=%0d data=%h want addr=%0d data=%h",
                                 out_addr, out_data, s_addr, s_data);
                    end
                end
                rdy = (k < pat_len) ? rdy_pat[k] : 1'b1;
                if (k == clr_at) begin
                    acc_clear = 1'b1;
                    mac_set_busy(last);
                end
                k++;
                out_ready = rdy;
                if (rdy) begin
                    e = sb.pop_front();
                    total++;
                    if ({out_addr, out_data, out_last} !== e) begin
                        bad++;
                        $display("FAIL drain_beat: got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                                 out_addr, out_data, out_last, e[22:17], e[16:1], e[0]);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_addr  = out_addr;
                    s_data  = out_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        idle();
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d beats pending want 0", sb.size());
            sb.delete();
        end
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL drain_end: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    // A MAC request while busy must be dropped; the model is left untouched.
    task automatic mac_set_busy(input logic [5:0] addr);
        comp_en_mem      = EN_W;
        in_act_value_mem = 16'h0100;
        out_act_addr_mem = addr;
        w_mem_q          = 16'h0100;
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid, out_last, busy, err, out_addr, out_data} !== 26'd0) begin
            bad++;
            $display("FAIL reset_hold: got v=%b l=%b b=%b e=%b a=%0d d=%h want all 0",
                     out_valid, out_last, busy, err, out_addr, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_last, busy, err, out_addr, out_data} !== 26'd0) begin
            bad++;
            $display("FAIL reset_release: got v=%b b=%b e=%b want 0", out_valid, busy, err);
        end
        model_zero();
    endtask

    task automatic test_basic_mac();
        mac_set(EN_W, 16'h0200, 6'd5, 16'h0180);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        run_drain(6'd5, 8'hFF, 0, -1);
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int i = 0; i < 4; i++) begin
            mac_set(EN_U, 16'h0100, 6'd3, 16'h0100);
            @(negedge clk);
        end
        mac_set(EN_V, 16'hFE80, 6'd1, 16'h0300);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        run_drain(6'd3, 8'hFF, 0, -1);
    endtask

    task automatic test_saturation();
        clear_all();
        mac_set(EN_W, 16'h7F00, 6'd7, 16'h0100);
        @(negedge clk);
        mac_set(EN_U, 16'h8000, 6'd8, 16'h0100);
        @(negedge clk);
        mac_set(EN_W, 16'h0200, 6'd7, 16'h0100);
        @(negedge clk);
        mac_set(EN_V, 16'hFF00, 6'd8, 16'h0100);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        run_drain(6'd8, 8'hFF, 0, -1);
    endtask

    task automatic test_backpressure();
        clear_all();
        mac_set(EN_W, 16'h0100, 6'd0, 16'h0A00);
        @(negedge clk);
        mac_set(EN_U, 16'h0300, 6'd1, 16'h0080);
        @(negedge clk);
        mac_set(EN_V, 16'hFF00, 6'd2, 16'h0500);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        run_drain(6'd2, 8'b0000_1101, 4, -1);
    endtask

    task automatic test_flush_clear();
        clear_all();
        // Update captured in the same cycle as drain_start must land before DRAIN.
        mac_set(EN_V, 16'h0300, 6'd0, 16'h0100);
        run_drain(6'd1, 8'hFF, 0, -1);
        // Clear coinciding with the stage-A write wins.
        mac_set(EN_W, 16'h0400, 6'd2, 16'h0100);
        @(negedge clk);
        idle();
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        model_zero();
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_quiet: got %b want 0", err);
        end
        mac_set(EN_U, 16'h0200, 6'd1, 16'h0200);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        // Clear and MAC both arrive mid-DRAIN and must be ignored.
        run_drain(6'd3, 8'hFF, 0, 1);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        mac_set(EN_W, 16'h0100, 6'd0, 16'h0200);
        @(negedge clk);
        mac_set(EN_W, 16'h0100, 6'd1, 16'h0300);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        drain_start = 1'b1;
        drain_last  = 6'd3;
        @(negedge clk);
        drain_start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_enter: got valid=%b want 1", out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_addr !== 6'd1) begin
            bad++;
            $display("FAIL one_xfer: got addr=%0d want 1", out_addr);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_last, busy, err, out_addr, out_data} !== 26'd0) begin
            bad++;
            $display("FAIL reset_abort: got v=%b b=%b e=%b a=%0d d=%h want all 0",
                     out_valid, busy, err, out_addr, out_data);
        end
        idle();
        @(negedge clk);
        rst = 1'b0;
        model_zero();
        @(negedge clk);
        run_drain(6'd63, 8'hFF, 0, -1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        in_act_value_mem = '0;
        out_act_addr_mem = '0;
        w_mem_q = '0; u_mem_q = '0; v_mem_q = '0;
        drain_last = '0;
        model_zero();
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_mac();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_flush_clear();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
